dd_stage: RTL and testbench

//  Parametrised data-distributor stage for the partitioned hash join.
//  - NUM_PAIRS input pairs; each pair routes tuples on bit DECISION_BIT of the hash digest to its zero or one output.
//  - Adds over the fixed 8-input stage: per-output FIFOs, round-robin arbitration and per-output tuple counters.
//  - Cascaded log2(partitions) times, with DECISION_BIT stepping per level, to build the radix partitioner.

---
 rtl/dd_pkg.sv | 22 ++
 rtl/dd_if.sv | 41 ++++
 rtl/dd_fifo.sv | 49 ++++
 rtl/dd_stage.sv | 105 ++++++++++
 tb/tb_dd_stage.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dd_pkg.sv
// Shared constants, output-select encoding and the round-robin helper for the
// hash-join data-distributor stage.
package dd_pkg;

    localparam int DD_INPUT_SIZE   = 64;
    localparam int DD_TAG_WIDTH    = 32;
    localparam int DD_NUM_PAIRS    = 4;
    localparam int DD_DECISION_BIT = 0;
    localparam int DD_FIFO_DEPTH   = 2;
    localparam int DD_CNT_WIDTH    = 32;

    typedef enum logic {
        OUT_ZERO = 1'b0,
        OUT_ONE  = 1'b1
    } dd_out_e;

    // The pointer only moves when a contended output actually grants.
    function automatic logic rr_next(logic ptr, logic conflict, logic grant);
        return (conflict && grant) ? ~ptr : ptr;
    endfunction

endpackage

// File: rtl/dd_if.sv
// Tuple streams of a distributor stage: 2*NUM_PAIRS inputs, a zero and a one
// output per pair, plus the per-output tuple counters.
interface dd_if
    import dd_pkg::*;
#(
    parameter int INPUT_SIZE = DD_INPUT_SIZE,
    parameter int TAG_WIDTH  = DD_TAG_WIDTH,
    parameter int NUM_PAIRS  = DD_NUM_PAIRS,
    parameter int CNT_WIDTH  = DD_CNT_WIDTH
);
    logic [2*NUM_PAIRS-1:0]                 in_valid;
    logic [2*NUM_PAIRS-1:0]                 in_ready;
    logic [2*NUM_PAIRS-1:0][INPUT_SIZE-1:0] in_data;
    logic [2*NUM_PAIRS-1:0][TAG_WIDTH-1:0]  in_tag;

    logic [NUM_PAIRS-1:0]                   zero_valid;
    logic [NUM_PAIRS-1:0]                   zero_ready;
    logic [NUM_PAIRS-1:0][INPUT_SIZE-1:0]   zero_data;
    logic [NUM_PAIRS-1:0][TAG_WIDTH-1:0]    zero_tag;

    logic [NUM_PAIRS-1:0]                   one_valid;
    logic [NUM_PAIRS-1:0]                   one_ready;
    logic [NUM_PAIRS-1:0][INPUT_SIZE-1:0]   one_data;
    logic [NUM_PAIRS-1:0][TAG_WIDTH-1:0]    one_tag;

    logic                                   cnt_clear;
    logic [NUM_PAIRS-1:0][CNT_WIDTH-1:0]    zero_cnt;
    logic [NUM_PAIRS-1:0][CNT_WIDTH-1:0]    one_cnt;

    modport master (
        output in_valid, in_data, in_tag, zero_ready, one_ready, cnt_clear,
        input  in_ready, zero_valid, zero_data, zero_tag, one_valid, one_data, one_tag,
        input  zero_cnt, one_cnt
    );

    modport slave (
        input  in_valid, in_data, in_tag, zero_ready, one_ready, cnt_clear,
        output in_ready, zero_valid, zero_data, zero_tag, one_valid, one_data, one_tag,
        output zero_cnt, one_cnt
    );
endinterface

// File: rtl/dd_fifo.sv
// Small synchronous FIFO with registered storage: a pushed word is visible at
// the head on the following cycle. A full FIFO refuses pushes even while popping.
module dd_fifo #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    output logic                      full,
    input  logic                      pop,
    output logic [DATA_W-1:0]         pop_data,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              do_push;
    logic              do_pop;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/dd_stage.sv
// Data-distributor stage: each input pair routes tuples on one digest bit to a
// per-pair zero/one output, with round-robin arbitration, output FIFOs and counters.
module dd_stage
    import dd_pkg::*;
#(
    parameter int INPUT_SIZE   = DD_INPUT_SIZE,
    parameter int TAG_WIDTH    = DD_TAG_WIDTH,
    parameter int NUM_PAIRS    = DD_NUM_PAIRS,
    parameter int DECISION_BIT = DD_DECISION_BIT,
    parameter int FIFO_DEPTH   = DD_FIFO_DEPTH,
    parameter int CNT_WIDTH    = DD_CNT_WIDTH
) (
    input  logic clk,
    input  logic resetn,
    dd_if.slave  bus
);
    localparam int DATA_W = INPUT_SIZE + TAG_WIDTH;
    localparam int NO     = 2 * NUM_PAIRS;
    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

    // Inputs stay refused until the first clock edge after reset is released.
    logic run_reg;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) run_reg <= 1'b0;
        else         run_reg <= 1'b1;
    end

    // grant_a[k] / grant_b[k]: input a / b of the owning pair wins output k.
    logic [NO-1:0] grant_a;
    logic [NO-1:0] grant_b;

    for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
        localparam int A = 2 * gi;
        localparam int B = 2 * gi + 1;

        logic tgt_a;
        logic tgt_b;
        assign tgt_a = bus.in_data[A][DECISION_BIT];
        assign tgt_b = bus.in_data[B][DECISION_BIT];

        for (genvar go = 0; go < 2; go++) begin : g_out
            localparam int      K   = 2 * gi + go;
            localparam dd_out_e SEL = (go == 0) ? OUT_ZERO : OUT_ONE;

            logic                 req_a, req_b, conflict, rr_reg;
            logic                 push, full, pop, empty;
            logic [DATA_W-1:0]    wdata, rdata;
            logic [FCW-1:0]       occ;
            logic [CNT_WIDTH-1:0] cnt_reg;

            assign req_a      = run_reg && bus.in_valid[A] && (tgt_a == SEL);
            assign req_b      = run_reg && bus.in_valid[B] && (tgt_b == SEL);
            assign conflict   = req_a && req_b;
            assign grant_a[K] = req_a && !full && (!conflict || !rr_reg);
            assign grant_b[K] = req_b && !full && (!conflict ||  rr_reg);
            assign push       = grant_a[K] || grant_b[K];
            assign wdata      = grant_b[K] ? {bus.in_data[B], bus.in_tag[B]}
                                           : {bus.in_data[A], bus.in_tag[A]};

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) rr_reg <= 1'b0;
                else         rr_reg <= rr_next(rr_reg, conflict, push);
            end

            dd_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .resetn    (resetn),
                .push      (push),
                .push_data (wdata),
                .full      (full),
                .pop       (pop),
                .pop_data  (rdata),
                .empty     (empty),
                .count     (occ)
            );

            // Clear wins over a same-cycle transfer; the count sticks at all-ones.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)                     cnt_reg <= '0;
                else if (bus.cnt_clear)          cnt_reg <= '0;
                else if (pop && cnt_reg != '1)   cnt_reg <= cnt_reg + 1'b1;
            end

            if (go == 0) begin : g_zero
                assign pop                 = (occ != '0) && bus.zero_ready[gi];
                assign bus.zero_valid[gi]  = !empty;
                assign bus.zero_data[gi]   = rdata[DATA_W-1:TAG_WIDTH];
                assign bus.zero_tag[gi]    = rdata[TAG_WIDTH-1:0];
                assign bus.zero_cnt[gi]    = cnt_reg;
            end else begin : g_one
                assign pop                 = (occ != '0) && bus.one_ready[gi];
                assign bus.one_valid[gi]   = !empty;
                assign bus.one_data[gi]    = rdata[DATA_W-1:TAG_WIDTH];
                assign bus.one_tag[gi]     = rdata[TAG_WIDTH-1:0];
                assign bus.one_cnt[gi]     = cnt_reg;
            end
        end

        assign bus.in_ready[A] = grant_a[A] || grant_a[B];
        assign bus.in_ready[B] = grant_b[A] || grant_b[B];
    end
endmodule

// File: tb/tb_dd_stage.sv
// Self-checking bench for dd_stage: directed scenarios plus random traffic,
// checked by a queue-based reference model sampled every cycle.
module tb_dd_stage;
    localparam int IS    = 64;
    localparam int TW    = 32;
    localparam int NP    = 4;
    localparam int DB    = 0;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int NO    = 2 * NP;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic [IS-1:0] d;
        logic [TW-1:0] t;
    } item_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    dd_if #(.INPUT_SIZE(IS), .TAG_WIDTH(TW), .NUM_PAIRS(NP), .CNT_WIDTH(CW)) bus ();

    dd_stage #(
        .INPUT_SIZE   (IS),
        .TAG_WIDTH    (TW),
        .NUM_PAIRS    (NP),
        .DECISION_BIT (DB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    item_t exp_q [NO][$];
    bit    rr_m [NO];
    int    cnt_m [NO];
    bit    started = 0;
    bit    async_hit = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NO; k++) begin
            exp_q[k].delete();
            rr_m[k]  = 1'b0;
            cnt_m[k] = 0;
        end
        started = 0;
    endtask

    // Reference model: occupancy is the number of tuples accepted but not yet
    // seen leaving; contention alternates via a per-output turn bit.
    task automatic monitor_step();
        logic [NO-1:0] exp_rdy = '0;
        bit   [NO-1:0] ga = '0;
        bit   [NO-1:0] gb = '0;
        bit   [NO-1:0] popped = '0;
        if (async_hit) begin
            model_clear();
            async_hit = 0;
        end
        if (!resetn) begin
            model_clear();
            chk("rst_in_ready", bus.in_ready, '0);
            chk("rst_valid", {bus.zero_valid, bus.one_valid}, '0);
            chk("rst_cnt", {bus.zero_cnt, bus.one_cnt}, '0);
            chk("rst_data", {bus.zero_data[0], bus.one_tag[NP-1]}, '0);
            return;
        end
        for (int p = 0; p < NP; p++) begin
            for (int o = 0; o < 2; o++) begin
                int k;
                bit ra, rb;
                k  = 2 * p + o;
                ra = bus.in_valid[2*p]   && (bus.in_data[2*p][DB]   == o[0]);
                rb = bus.in_valid[2*p+1] && (bus.in_data[2*p+1][DB] == o[0]);
                if (started && exp_q[k].size() < DEPTH) begin
                    if (ra && rb) begin
                        if (rr_m[k]) gb[k] = 1; else ga[k] = 1;
                        rr_m[k] = !rr_m[k];
                    end else if (ra) ga[k] = 1;
                    else if (rb)     gb[k] = 1;
                end
                if (ga[k]) exp_rdy[2*p]   = 1'b1;
                if (gb[k]) exp_rdy[2*p+1] = 1'b1;
            end
        end
        chk("in_ready", bus.in_ready, exp_rdy);
        for (int k = 0; k < NO; k++) begin
            int p;
            logic v, r;
            logic [CW-1:0] c;
            item_t act;
            p = k / 2;
            if (k % 2 == 0) begin
                v = bus.zero_valid[p]; r = bus.zero_ready[p];
                act = {bus.zero_data[p], bus.zero_tag[p]}; c = bus.zero_cnt[p];
            end else begin
                v = bus.one_valid[p]; r = bus.one_ready[p];
                act = {bus.one_data[p], bus.one_tag[p]}; c = bus.one_cnt[p];
            end
            chk($sformatf("valid_%0d", k), v, exp_q[k].size() > 0);
            if (exp_q[k].size() > 0) begin
                chk($sformatf("data_tag_%0d", k), act, exp_q[k][0]);
                if (r) begin
                    void'(exp_q[k].pop_front());
                    popped[k] = 1;
                end
            end
            chk($sformatf("cnt_%0d", k), c, cnt_m[k]);
        end
        for (int k = 0; k < NO; k++) begin
            if (bus.cnt_clear)                    cnt_m[k] = 0;
            else if (popped[k] && cnt_m[k] < CMAX) cnt_m[k]++;
        end
        for (int p = 0; p < NP; p++) begin
            for (int o = 0; o < 2; o++) begin
                if (ga[2*p+o]) exp_q[2*p+o].push_back({bus.in_data[2*p],   bus.in_tag[2*p]});
                if (gb[2*p+o]) exp_q[2*p+o].push_back({bus.in_data[2*p+1], bus.in_tag[2*p+1]});
            end
        end
        started = 1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            monitor_step();
        end
    end

    task automatic idle();
        bus.in_valid   = '0;
        bus.zero_ready = '1;
        bus.one_ready  = '1;
        bus.cnt_clear  = 1'b0;
    endtask

    initial begin
        bus.in_valid   = '1;
        bus.in_data    = '0;
        bus.in_tag     = '0;
        bus.zero_ready = '1;
        bus.one_ready  = '1;
        bus.cnt_clear  = 1'b0;

        // Reset held for 3 cycles with every input valid
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        bus.in_valid = 8'h01;
        bus.in_data[0] = 64'h100;
        bus.in_tag[0]  = 32'hF00D;
        @(negedge clk);
        #3 chk("first_out_c1", bus.zero_valid[0], 1'b0);
        @(negedge clk);
        #3 chk("first_out_c2", bus.zero_valid[0], 1'b1);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);

        // Split: a to zero[0], b to one[0] in the same cycle
        bus.in_valid   = 8'h03;
        bus.in_data[0] = 64'hABCD_0000_0000_1200;
        bus.in_tag[0]  = 32'h0000_AAAA;
        bus.in_data[1] = 64'hABCD_0000_0000_3401;
        bus.in_tag[1]  = 32'h0000_BBBB;
        #3 chk("split_ready", bus.in_ready[1:0], 2'b11);
        @(negedge clk);
        bus.in_valid = '0;
        #3 chk("split_valid", {bus.zero_valid[0], bus.one_valid[0]}, 2'b11);
        chk("split_tag", {bus.zero_tag[0], bus.one_tag[0]}, {32'h0000_AAAA, 32'h0000_BBBB});
        repeat (2) @(negedge clk);

        // Contention: both inputs of pair 0 target zero[0] for 8 cycles
        bus.cnt_clear = 1'b1;
        @(negedge clk);
        bus.cnt_clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid   = 8'h03;
            bus.in_data[0] = 64'h1000 + 64'(i << 4);
            bus.in_tag[0]  = 32'(i);
            bus.in_data[1] = 64'h2000 + 64'(i << 4);
            bus.in_tag[1]  = 32'(100 + i);
            #3 chk("contend_rr", bus.in_ready[1:0], (i % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
        end
        bus.in_valid = '0;
        repeat (3) @(negedge clk);
        #3 chk("contend_cnt", bus.zero_cnt[0], 4'd8);

        // Backpressure: zero[0] stalled, only DEPTH tuples accepted
        @(negedge clk);
        bus.zero_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid   = 8'h01;
            bus.in_data[0] = 64'h5000 + 64'(i << 4);
            bus.in_tag[0]  = 32'(200 + i);
            #3 chk("bp_ready", bus.in_ready[0], i < DEPTH);
            @(negedge clk);
        end
        idle();
        repeat (4) @(negedge clk);

        // Counter saturation on one[1], then clear during a transfer
        bus.cnt_clear = 1'b1;
        @(negedge clk);
        bus.cnt_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid   = 8'h04;
            bus.in_data[2] = 64'h7001 + 64'(i << 4);
            bus.in_tag[2]  = 32'(300 + i);
            @(negedge clk);
        end
        bus.in_valid = '0;
        repeat (3) @(negedge clk);
        #3 chk("sat_cnt", bus.one_cnt[1], 4'd15);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid   = 8'h04;
            bus.in_data[2] = 64'h8001 + 64'(i << 4);
            bus.cnt_clear  = (i == 2);
            if (i == 3) #3 chk("clear_cnt", bus.one_cnt[1], 4'd0);
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid   = NO'($urandom);
            bus.zero_ready = NP'($urandom | $urandom);
            bus.one_ready  = NP'($urandom | $urandom);
            bus.cnt_clear  = ($urandom_range(0, 31) == 0);
            for (int j = 0; j < NO; j++) begin
                bus.in_data[j] = {$urandom, $urandom};
                bus.in_tag[j]  = $urandom;
            end
            @(negedge clk);
        end
        idle();
        repeat (4) @(negedge clk);

        // Asynchronous reset with half-full FIFOs
        bus.zero_ready = '0;
        bus.one_ready  = '0;
        bus.in_valid   = 8'h55;
        for (int j = 0; j < NO; j++) begin
            bus.in_data[j] = {$urandom, $urandom};
            bus.in_tag[j]  = $urandom;
        end
        @(negedge clk);
        bus.in_valid = '0;
        @(posedge clk);
        #1 resetn = 1'b0;
        async_hit = 1;
        #1 chk("async_drop", {bus.zero_valid, bus.one_valid, bus.in_ready}, '0);
        #1 resetn = 1'b1;
        @(negedge clk);
        idle();
        repeat (5) @(negedge clk);
        #3 chk("no_stale", {bus.zero_valid, bus.one_valid}, '0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
